helios_single_fpga: RTL and testbench
=====================================

Name: helios_single_fpga

Overview:
- Single-FPGA top-level of the Helios union-find QEC decoder, speaking a byte-stream valid/ready protocol.
- Sits between two 8-bit fifo_wrapper instances, one on the host-input side and one on the host-output side.
- Parses the host commands, assembles one measurement window per request, and runs the decode core.
- Returns a 3-byte report per decode: iteration count, then cycle count.

Parameters:
- GRID_WIDTH_X, 4: lattice width in X (code distance + 1).
- GRID_WIDTH_Z, 1: lattice width in Z.
- GRID_WIDTH_U, 5: processing units along time, 2*d-1.
- MAX_WEIGHT, 2: edge weight, passed to the core.
- Derived, BYTES_PER_ROUND: ceil(GX*GZ/8).
- Derived, ALIGNED_PU_PER_ROUND: BYTES_PER_ROUND*8.
- Derived, MEAS_ROUNDS: GRID_WIDTH_X-1.
- Derived, PU_COUNT: GX*GZ*GU.
- Derived, ADDRESS_WIDTH: clog2(GX)+clog2(GZ)+clog2(GU).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- input_data  in  8  command or measurement byte.
- input_valid  in  1  input byte present.
- input_ready  out  1  block accepts input byte.
- output_data  out  8  report byte.
- output_valid  out  1  report byte present.
- output_ready  in  1  downstream accepts report byte.

Behaviour:
- Handshake: a byte transfers on a rising clk edge where valid && ready. Once output_valid is high, output_data holds stable until accepted.
- Reset values: input_ready=0, output_valid=0, output_data=0; FSM=IDLE; all counters and the measurement register are 0.
- FSM, IDLE: input_ready=1. A START_DECODING_MSG byte moves to WAIT_HDR. Any other byte is consumed and dropped.
- FSM, WAIT_HDR: input_ready=1. MEASUREMENT_DATA_HEADER clears the measurement register and byte_cnt, then moves to LOAD. Other bytes are dropped.
- FSM, LOAD: input_ready=1.
  - Byte n is written to meas[8n+:8].
  - After byte BYTES_PER_ROUND*MEAS_ROUNDS-1 is accepted, go to DECODE. For d=3 this is 3 bytes.
  - Bit layout: bit index = x*GZ + z + round*ALIGNED_PU_PER_ROUND. Padding bits are ignored.
- FSM, DECODE: input_ready=0.
  - On the entry cycle, pulse core start for 1 cycle; cycle_cnt is reset to 1.
  - cycle_cnt increments every cycle until core done. It is 16 bits and saturates at 16'hFFFF.
  - On done, latch iterations (8 bits, saturating) and go to REPORT.
- FSM, REPORT: output_valid=1. Byte order: iterations, cycle_cnt[15:8], cycle_cnt[7:0]. After the third byte is accepted, output_valid drops and the FSM returns to WAIT_HDR (no new START needed).
- Back-pressure: output_ready low stalls REPORT indefinitely with no data change.
- Async reset mid-operation: everything aborts to IDLE and any partial report is discarded.
- Simultaneous events: input_ready is never high while output_valid is high.
- Hierarchy-visible signals, exact names required:
  - roots [ADDRESS_WIDTH*PU_COUNT]. Entry for PU index x*GZ + z + u*GZ*GX is packed {u, x, z}, with z in the LSBs.
  - output_streaming_corrected_syndrome [PU_COUNT], same indexing.
  - Both are driven by the core and stable from done until the next start.

Decomposition:
- Package helios_pkg:
  - START_DECODING_MSG = 8'h01.
  - MEASUREMENT_DATA_HEADER = 8'h02.
  - FSM state enum {IDLE, WAIT_HDR, LOAD, DECODE, REPORT}.
  - Width helper functions.
- Sub-module helios_decode_core (specified separately), ports:
  - start, measurements[ALIGNED_PU_PER_ROUND*MEAS_ROUNDS], done, iterations[7:0], roots, corrected_syndrome.
- This block is the protocol controller plus the core instantiation.
- fifo_wrapper (WIDTH, DEPTH) is an existing block and is not part of this scope.

Test Plan:
- Reset: hold reset=0 for 10 cycles, then release. Required: output_valid=0, input_ready=1 (IDLE). Send 8'h55 and verify it is dropped with FSM still in IDLE.
- Nominal (core stub with done 7 cycles after start, iterations=3): send 01, 02, 00, 00, 00. Required output bytes: 03, 00, 08.
- Back-pressure: same stimulus with output_ready held low for 20 cycles. output_valid stays 1 with output_data=03; after release, bytes 03, 00, 08 arrive in order.
- Back-to-back windows: after the report, send 02, A5, 0F, 01 without a new START. A second 3-byte report is produced, and the stub records measurements={01,0F,A5}.
- Saturation: stub done after 70000 cycles with iterations=300. Required bytes: FF, FF, FF.
- Reset mid-LOAD: after 02 plus 1 data byte, assert reset. FSM goes to IDLE and no report is emitted. A full 01, 02, 00, 00, 00 sequence then decodes normally.

Source files
------------

// File: rtl/helios_pkg.sv
// helios_pkg: shared constants, FSM state type and width helpers for the
// Helios single-FPGA decoder top and its decode core.
//   START_DECODING_MSG / MEASUREMENT_DATA_HEADER : host command bytes
//   fsm_state_e                                  : protocol controller states
//   *_width / pu_count helpers                   : derived lattice sizes
package helios_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    // Reported cycle count and the core's raw iteration count widths.
    localparam int CYCLE_W      = 16;
    localparam int ITER_W       = 16;
    localparam int REPORT_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HDR,
        LOAD,
        DECODE,
        REPORT
    } fsm_state_e;

    function automatic int bytes_per_round(input int gx, input int gz);
        return (gx * gz + 7) / 8;
    endfunction

    // Measurement window: (GX-1) rounds, each padded to a whole byte count.
    function automatic int meas_width(input int gx, input int gz);
        return bytes_per_round(gx, gz) * 8 * (gx - 1);
    endfunction

    function automatic int pu_count(input int gx, input int gz, input int gu);
        return gx * gz * gu;
    endfunction

    function automatic int address_width(input int gx, input int gz, input int gu);
        return $clog2(gx) + $clog2(gz) + $clog2(gu);
    endfunction

    // Bits needed to hold values 0..n (at least one bit).
    function automatic int count_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/helios_decode_core.sv
// helios_decode_core: decode core behind the Helios protocol controller.
// This implementation models the core's interface timing: every processing
// unit stays its own cluster root, the corrected syndrome is the syndrome
// captured at start, and done pulses LATENCY cycles after start carrying a
// fixed ITERATIONS count.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, captures measurements
//   measurements        : byte-aligned measurement rounds
//   done                : one-cycle pulse when decoding finishes
//   iterations          : growth iterations used (valid with done)
//   roots               : per-PU root address, packed {u, x, z}
//   corrected_syndrome  : per-PU syndrome, stable from done to next start
module helios_decode_core
    import helios_pkg::*;
#(
    parameter int GRID_WIDTH_X = 4,
    parameter int GRID_WIDTH_Z = 1,
    parameter int GRID_WIDTH_U = 5,
    parameter int MAX_WEIGHT   = 2,
    parameter int LATENCY      = 7,
    parameter int ITERATIONS   = 3
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [meas_width(GRID_WIDTH_X, GRID_WIDTH_Z)-1:0] measurements,
    output logic                                        done,
    output logic [ITER_W-1:0]                           iterations,
    output logic [address_width(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U)
                  * pu_count(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U)-1:0] roots,
    output logic [pu_count(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U)-1:0] corrected_syndrome
);

    localparam int GX          = GRID_WIDTH_X;
    localparam int GZ          = GRID_WIDTH_Z;
    localparam int GU          = GRID_WIDTH_U;
    localparam int XW          = $clog2(GX);
    localparam int ZW          = $clog2(GZ);
    localparam int AW          = address_width(GX, GZ, GU);
    localparam int PU          = pu_count(GX, GZ, GU);
    localparam int MEAS_W      = meas_width(GX, GZ);
    localparam int ALIGNED     = bytes_per_round(GX, GZ) * 8;
    localparam int MEAS_ROUNDS = GX - 1;

    // Edge weight only shapes growth in a full cluster implementation.
    localparam int unused_max_weight = MAX_WEIGHT;

    logic          busy_q;
    logic [31:0]   lat_cnt_q;
    logic [PU-1:0] syn_q;
    logic [PU-1:0] syn_now;
    logic [MEAS_W-1:0] unused_meas;

    // Padding bits of each round carry no syndrome information.
    assign unused_meas = measurements;

    for (genvar u = 0; u < GU; u++) begin : g_u
        for (genvar x = 0; x < GX; x++) begin : g_x
            for (genvar z = 0; z < GZ; z++) begin : g_z
                localparam int PU_IDX = x * GZ + z + u * GZ * GX;
                localparam int ROOT   = (u << (XW + ZW)) | (x << ZW) | z;
                assign roots[PU_IDX*AW +: AW] = AW'(ROOT);
                // Only the first MEAS_ROUNDS time slices receive measurements.
                if (u < MEAS_ROUNDS) begin : g_meas
                    assign syn_now[PU_IDX] = measurements[x*GZ + z + u*ALIGNED];
                end else begin : g_pad
                    assign syn_now[PU_IDX] = 1'b0;
                end
            end
        end
    end

    assign done               = busy_q && (lat_cnt_q == 32'(LATENCY));
    assign iterations         = ITER_W'(ITERATIONS);
    assign corrected_syndrome = syn_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            lat_cnt_q <= '0;
            syn_q     <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            lat_cnt_q <= 32'd1;
            syn_q     <= syn_now;
        end else if (done) begin
            busy_q    <= 1'b0;
        end else if (busy_q) begin
            lat_cnt_q <= lat_cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/helios_single_fpga.sv
// helios_single_fpga: byte-stream protocol controller for the Helios
// union-find decoder. Waits for a START byte, then repeatedly accepts a
// measurement header plus one window of measurement bytes, runs the decode
// core and returns a 3-byte report {iterations, cycles[15:8], cycles[7:0]}.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   input_data/valid/ready          : host command and measurement bytes
//   output_data/valid/ready         : report bytes
// roots and output_streaming_corrected_syndrome are internal nets kept for
// hierarchical observation of the core result.
module helios_single_fpga
    import helios_pkg::*;
#(
    parameter int GRID_WIDTH_X    = 4,
    parameter int GRID_WIDTH_Z    = 1,
    parameter int GRID_WIDTH_U    = 5,
    parameter int MAX_WEIGHT      = 2,
    parameter int CORE_LATENCY    = 7,
    parameter int CORE_ITERATIONS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] input_data,
    input  logic       input_valid,
    output logic       input_ready,
    output logic [7:0] output_data,
    output logic       output_valid,
    input  logic       output_ready
);

    localparam int BYTES_PER_ROUND      = bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z);
    localparam int ALIGNED_PU_PER_ROUND = BYTES_PER_ROUND * 8;
    localparam int MEAS_ROUNDS          = GRID_WIDTH_X - 1;
    localparam int PU_COUNT             = pu_count(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
    localparam int ADDRESS_WIDTH        = address_width(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
    localparam int MEAS_W               = ALIGNED_PU_PER_ROUND * MEAS_ROUNDS;
    localparam int LOAD_BYTES           = BYTES_PER_ROUND * MEAS_ROUNDS;
    localparam int BCNT_W               = count_width(LOAD_BYTES);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(LOAD_BYTES - 1);
    localparam logic [1:0]        LAST_RPT  = 2'(REPORT_BYTES - 1);

    function automatic logic [CYCLE_W-1:0] cycle_inc(input logic [CYCLE_W-1:0] c);
        return (&c) ? c : c + CYCLE_W'(1);
    endfunction

    function automatic logic [7:0] iter_sat(input logic [ITER_W-1:0] it);
        return (it > ITER_W'(255)) ? 8'hFF : it[7:0];
    endfunction

    function automatic logic [7:0] report_byte(input logic [1:0]         idx,
                                               input logic [7:0]         it,
                                               input logic [CYCLE_W-1:0] cyc);
        case (idx)
            2'd0:    return it;
            2'd1:    return cyc[15:8];
            default: return cyc[7:0];
        endcase
    endfunction

    fsm_state_e          state_q, state_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [MEAS_W-1:0]   meas_q, meas_d;
    logic [CYCLE_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [7:0]          iter_q, iter_d;
    logic [1:0]          rpt_idx_q, rpt_idx_d;
    logic                start_q, start_d;
    logic                in_rdy_q, in_rdy_d;
    logic                out_vld_q, out_vld_d;
    logic [7:0]          out_data_q, out_data_d;

    logic                in_fire;
    logic                out_fire;
    logic                core_done;
    logic [ITER_W-1:0]   core_iter;

    logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots;
    logic [PU_COUNT-1:0]               output_streaming_corrected_syndrome;
    logic                              unused_observe;

    assign unused_observe = ^{roots, output_streaming_corrected_syndrome};

    assign in_fire      = input_valid && in_rdy_q;
    assign out_fire     = out_vld_q && output_ready;
    assign input_ready  = in_rdy_q;
    assign output_valid = out_vld_q;
    assign output_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        meas_d      = meas_q;
        cycle_cnt_d = cycle_cnt_q;
        iter_d      = iter_q;
        rpt_idx_d   = rpt_idx_q;
        start_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_fire && input_data == START_DECODING_MSG) begin
                    state_d = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (in_fire && input_data == MEASUREMENT_DATA_HEADER) begin
                    meas_d     = '0;
                    byte_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    for (int i = 0; i < LOAD_BYTES; i++) begin
                        if (byte_cnt_q == BCNT_W'(i)) begin
                            meas_d[i*8 +: 8] = input_data;
                        end
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Entry into DECODE: the core sees start on the first
                        // DECODE cycle, which already counts as cycle 1.
                        state_d     = DECODE;
                        start_d     = 1'b1;
                        cycle_cnt_d = CYCLE_W'(1);
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end
            end
            DECODE: begin
                if (core_done) begin
                    iter_d    = iter_sat(core_iter);
                    rpt_idx_d = '0;
                    state_d   = REPORT;
                end else begin
                    cycle_cnt_d = cycle_inc(cycle_cnt_q);
                end
            end
            REPORT: begin
                if (out_fire) begin
                    if (rpt_idx_q == LAST_RPT) begin
                        state_d = WAIT_HDR;
                    end else begin
                        rpt_idx_d = rpt_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so ready and
        // valid are never high together and hold steady under back-pressure.
        in_rdy_d   = (state_d == IDLE) || (state_d == WAIT_HDR) || (state_d == LOAD);
        out_vld_d  = (state_d == REPORT);
        out_data_d = out_vld_d ? report_byte(rpt_idx_d, iter_d, cycle_cnt_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            meas_q      <= '0;
            cycle_cnt_q <= '0;
            iter_q      <= '0;
            rpt_idx_q   <= '0;
            start_q     <= 1'b0;
            in_rdy_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            meas_q      <= meas_d;
            cycle_cnt_q <= cycle_cnt_d;
            iter_q      <= iter_d;
            rpt_idx_q   <= rpt_idx_d;
            start_q     <= start_d;
            in_rdy_q    <= in_rdy_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
        end
    end

    helios_decode_core #(
        .GRID_WIDTH_X (GRID_WIDTH_X),
        .GRID_WIDTH_Z (GRID_WIDTH_Z),
        .GRID_WIDTH_U (GRID_WIDTH_U),
        .MAX_WEIGHT   (MAX_WEIGHT),
        .LATENCY      (CORE_LATENCY),
        .ITERATIONS   (CORE_ITERATIONS)
    ) u_core (
        .clk                (clk),
        .reset              (reset),
        .start              (start_q),
        .measurements       (meas_q),
        .done               (core_done),
        .iterations         (core_iter),
        .roots              (roots),
        .corrected_syndrome (output_streaming_corrected_syndrome)
    );

endmodule

// File: tb/tb_helios_single_fpga.sv
module tb_helios_single_fpga;
    import helios_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Nominal instance: core finishes 7 cycles after start with 3 iterations.
    logic       reset, input_valid, input_ready, output_valid, output_ready;
    logic [7:0] input_data, output_data;
    // Saturation instance: core finishes after 70000 cycles with 300 iterations.
    logic       s_reset, s_input_valid, s_input_ready, s_output_valid, s_output_ready;
    logic [7:0] s_input_data, s_output_data;

    helios_single_fpga #(
        .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(5), .MAX_WEIGHT(2),
        .CORE_LATENCY(7), .CORE_ITERATIONS(3)
    ) dut (
        .clk(clk), .reset(reset),
        .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
        .output_data(output_data), .output_valid(output_valid), .output_ready(output_ready)
    );

    helios_single_fpga #(
        .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(5), .MAX_WEIGHT(2),
        .CORE_LATENCY(70000), .CORE_ITERATIONS(300)
    ) dut_sat (
        .clk(clk), .reset(s_reset),
        .input_data(s_input_data), .input_valid(s_input_valid), .input_ready(s_input_ready),
        .output_data(s_output_data), .output_valid(s_output_valid), .output_ready(s_output_ready)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sat_q[$];
    logic [7:0] mon_e, mon_s;
    logic       overlap_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h", name, act);
    endtask

    // Scoreboard monitors: a byte transfers on the posedge after a negedge
    // where valid and ready are both high.
    always @(negedge clk) begin
        if (output_valid && output_ready) begin
            if (exp_q.size() == 0) fail_now("main unexpected report byte", 32'(output_data));
            else begin
                mon_e = exp_q.pop_front();
                check("main report byte", 32'(output_data), 32'(mon_e));
            end
        end
        if (s_output_valid && s_output_ready) begin
            if (sat_q.size() == 0) fail_now("sat unexpected report byte", 32'(s_output_data));
            else begin
                mon_s = sat_q.pop_front();
                check("sat report byte", 32'(s_output_data), 32'(mon_s));
            end
        end
        if ((input_ready && output_valid) || (s_input_ready && s_output_valid))
            overlap_seen = 1'b1;
    end

    task automatic send_main(input logic [7:0] b);
        int guard = 0;
        bit acc   = 1'b0;
        input_data  = b;
        input_valid = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk); acc = input_ready;
            @(posedge clk); guard++;
        end
        #1;
        input_valid = 1'b0;
        input_data  = 8'h00;
        if (!acc) fail_now("main input accept timeout", 32'(b));
    endtask

    task automatic send_sat(input logic [7:0] b);
        int guard = 0;
        bit acc   = 1'b0;
        s_input_data  = b;
        s_input_valid = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk); acc = s_input_ready;
            @(posedge clk); guard++;
        end
        #1;
        s_input_valid = 1'b0;
        s_input_data  = 8'h00;
        if (!acc) fail_now("sat input accept timeout", 32'(b));
    endtask

    task automatic push_main(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    endtask

    task automatic drain_main(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            fail_now("main report timeout, bytes left", 32'(exp_q.size()));
            exp_q.delete();
        end
    endtask

    task automatic send_window(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_main(b0); send_main(b1); send_main(b2);
    endtask

    initial begin
        reset = 1'b0; input_valid = 1'b0; input_data = 8'h00; output_ready = 1'b1;
        s_reset = 1'b0; s_input_valid = 1'b0; s_input_data = 8'h00; s_output_ready = 1'b1;
        fork
            begin : main_seq
                bit stable;
                int n;
                // Reset
                repeat (10) @(posedge clk);
                #1;
                check("reset input_ready", 32'(input_ready), 32'd0);
                check("reset output_valid", 32'(output_valid), 32'd0);
                check("reset output_data", 32'(output_data), 32'd0);
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                check("idle input_ready", 32'(input_ready), 32'd1);
                check("idle output_valid", 32'(output_valid), 32'd0);
                check("idle state", 32'(dut.state_q), 32'(IDLE));
                send_main(8'h55);
                repeat (2) @(posedge clk);
                #1;
                check("junk byte keeps IDLE", 32'(dut.state_q), 32'(IDLE));
                check("junk byte input_ready", 32'(input_ready), 32'd1);

                // Nominal decode
                push_main(8'h03, 8'h00, 8'h08);
                send_main(8'h01); send_main(8'h02);
                send_window(8'h00, 8'h00, 8'h00);
                drain_main(100);
                check("after report state", 32'(dut.state_q), 32'(WAIT_HDR));
                check("root of PU 19", 32'(dut.roots[19*5 +: 5]), 32'd19);
                check("root of PU 6", 32'(dut.roots[6*5 +: 5]), 32'd6);

                // Back-to-back window, no new START
                push_main(8'h03, 8'h00, 8'h08);
                send_main(8'h02);
                send_window(8'hA5, 8'h0F, 8'h01);
                drain_main(100);
                check("b2b core measurements", 32'(dut.u_core.measurements), 32'h010FA5);
                check("b2b corrected syndrome", 32'(dut.output_streaming_corrected_syndrome), 32'h001F5);

                // Back-pressure
                output_ready = 1'b0;
                push_main(8'h03, 8'h00, 8'h08);
                send_main(8'h01); send_main(8'h02);
                send_window(8'h00, 8'h00, 8'h00);
                n = 0;
                while (!output_valid && n < 50) begin @(posedge clk); #1; n++; end
                check("bp output_valid", 32'(output_valid), 32'd1);
                check("bp first byte", 32'(output_data), 32'h03);
                check("bp input_ready low", 32'(input_ready), 32'd0);
                stable = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (!output_valid || output_data != 8'h03) stable = 1'b0;
                end
                check("bp 20-cycle hold", 32'(stable), 32'd1);
                check("bp bytes still queued", 32'(exp_q.size()), 32'd3);
                output_ready = 1'b1;
                drain_main(100);

                // Reset mid-LOAD
                send_main(8'h02); send_main(8'hA5);
                check("mid-load state", 32'(dut.state_q), 32'(LOAD));
                reset = 1'b0;
                #1;
                check("async reset state", 32'(dut.state_q), 32'(IDLE));
                check("async reset meas", 32'(dut.meas_q), 32'd0);
                check("async reset input_ready", 32'(input_ready), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                check("post-reset idle", 32'(dut.state_q), 32'(IDLE));
                push_main(8'h03, 8'h00, 8'h08);
                send_main(8'h01); send_main(8'h02);
                send_window(8'h00, 8'h00, 8'h00);
                drain_main(100);
            end
            begin : sat_seq
                int n;
                repeat (10) @(posedge clk);
                #1;
                s_reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                sat_q.push_back(8'hFF); sat_q.push_back(8'hFF); sat_q.push_back(8'hFF);
                send_sat(8'h01); send_sat(8'h02);
                send_sat(8'h00); send_sat(8'h00); send_sat(8'h00);
                n = 0;
                while (sat_q.size() != 0 && n < 80000) begin @(posedge clk); n++; end
                @(posedge clk); #1;
                if (sat_q.size() != 0) fail_now("sat report timeout, bytes left", 32'(sat_q.size()));
                check("sat return to WAIT_HDR", 32'(dut_sat.state_q), 32'(WAIT_HDR));
            end
        join
        check("ready/valid overlap seen", 32'(overlap_seen), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
